// File: rtl/param_code_lock.sv
// Parametrised combination lock: CODE_LEN single-switch presses unlock it, failed attempts trigger lockouts and then a latched alarm.
// Optional `CODE_PROG_EN adds a PROGRAM state so the code can be re-entered while unlocked.
module param_code_lock #(
  parameter int NUM_SW         = 8,
  parameter int CODE_LEN       = 4,
  parameter logic [CODE_LEN*((NUM_SW > 1) ? $clog2(NUM_SW) : 1)-1:0] CODE_INIT = 12'h688,
  parameter int MAX_TRIES      = 3,
  parameter int UNLOCK_CYCLES  = 300,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_SW-1:0]              switches,
  input  logic                           relock,
  input  logic                           prog_req,
  output logic                           locked,
  output logic                           alarm,
  output logic                           lockout,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
  output logic [$clog2(CODE_LEN+1)-1:0]  progress
);

  localparam int IW   = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;
  localparam int TW   = $clog2(MAX_TRIES + 1);
  localparam int PW   = $clog2(CODE_LEN + 1);
  localparam int CW   = CODE_LEN * IW;
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMW  = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [2:0] ST_ENTRY    = 3'd0;
  localparam logic [2:0] ST_UNLOCKED = 3'd1;
  localparam logic [2:0] ST_PROGRAM  = 3'd2;
  localparam logic [2:0] ST_LOCKOUT  = 3'd3;
  localparam logic [2:0] ST_ALARM    = 3'd4;

  localparam logic [PW-1:0]  LAST_POS    = PW'(CODE_LEN - 1);
  localparam logic [TMW-1:0] UNLOCK_LAST = TMW'(UNLOCK_CYCLES - 1);
  localparam logic [TMW-1:0] LOCK_LAST   = TMW'(LOCKOUT_CYCLES - 1);

  logic [2:0]        state;
  logic [TMW-1:0]    timer;
  logic [CW-1:0]     code;
  logic [NUM_SW-1:0] s1, s2, rise;
  logic              press, multi;
  logic [IW-1:0]     idx, exp_idx;

  assign rise  = s1 & ~s2;
  assign press = ($countones(rise) == 1);
  assign multi = ($countones(rise) > 1);

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    idx     = '0;
    exp_idx = '0;
    for (int i = 0; i < NUM_SW; i++)
      if (rise[i]) idx = IW'(i);
    for (int i = 0; i < CODE_LEN; i++)
      if (PW'(i) == progress) exp_idx = code[i*IW +: IW];
  end

`ifdef CODE_PROG_EN
  logic [CW-1:0] shadow, shadow_upd;

  // Shadow with the current press merged in, so the final press lands in the committed code.
  always_comb begin
    shadow_upd = shadow;
    for (int i = 0; i < CODE_LEN; i++)
      if (PW'(i) == progress) shadow_upd[i*IW +: IW] = idx;
  end
`else
  logic unused_prog_req;
  assign unused_prog_req = prog_req;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_ENTRY;
      tries_left <= TW'(MAX_TRIES);
      progress   <= '0;
      timer      <= '0;
      code       <= CODE_INIT;
      s1         <= '0;
      s2         <= '0;
`ifdef CODE_PROG_EN
      shadow     <= '0;
`endif
    end else begin
      s1 <= switches;
      s2 <= s1;
      case (state)
        ST_ENTRY: begin
          timer <= '0;
          if (multi || (press && idx != exp_idx)) begin
            progress <= '0;
            if (tries_left <= TW'(1)) begin
              tries_left <= '0;
              state      <= ST_ALARM;
            end else begin
              tries_left <= tries_left - TW'(1);
              state      <= ST_LOCKOUT;
            end
          end else if (press) begin
            if (progress == LAST_POS) begin
              progress   <= '0;
              tries_left <= TW'(MAX_TRIES);
              state      <= ST_UNLOCKED;
            end else begin
              progress <= progress + PW'(1);
            end
          end
        end

        ST_LOCKOUT: begin
          if (timer == LOCK_LAST) begin
            timer <= '0;
            state <= ST_ENTRY;
          end else begin
            timer <= timer + TMW'(1);
          end
        end

        ST_UNLOCKED: begin
          if (relock || timer == UNLOCK_LAST) begin
            timer <= '0;
            state <= ST_ENTRY;
`ifdef CODE_PROG_EN
          end else if (prog_req) begin
            timer    <= '0;
            progress <= '0;
            state    <= ST_PROGRAM;
`endif
          end else begin
            timer <= timer + TMW'(1);
          end
        end

`ifdef CODE_PROG_EN
        // An abort leaves code untouched; only a complete entry commits the shadow.
        ST_PROGRAM: begin
          if (multi || timer == UNLOCK_LAST) begin
            timer    <= '0;
            progress <= '0;
            state    <= ST_ENTRY;
          end else begin
            timer <= timer + TMW'(1);
            if (press) begin
              shadow <= shadow_upd;
              if (progress == LAST_POS) begin
                code     <= shadow_upd;
                timer    <= '0;
                progress <= '0;
                state    <= ST_UNLOCKED;
              end else begin
                progress <= progress + PW'(1);
              end
            end
          end
        end
`endif

        ST_ALARM: begin
          timer      <= '0;
          tries_left <= '0;
        end

        default: begin
          timer <= '0;
          state <= ST_ENTRY;
        end
      endcase
    end
  end

  assign locked  = !(state == ST_UNLOCKED || state == ST_PROGRAM);
  assign alarm   = (state == ST_ALARM);
  assign lockout = (state == ST_LOCKOUT);

endmodule
